// File: rtl/tug_playfield_if.sv
// Player-facing signal bundle for the tug-of-war light bar: raw keys and round
// control in, LED bar, edge flags, win strobes and scores out.
interface tug_playfield_if #(
  parameter int N_LIGHTS = 9,
  parameter int SCORE_W  = 3
);
  logic                L;
  logic                R;
  logic                new_round;
  logic [N_LIGHTS-1:0] lights;
  logic                LE;
  logic                RE;
  logic                win_L;
  logic                win_R;
  logic [SCORE_W-1:0]  score_L;
  logic [SCORE_W-1:0]  score_R;

  modport master (
    output L, R, new_round,
    input  lights, LE, RE, win_L, win_R, score_L, score_R
  );

  modport slave (
    input  L, R, new_round,
    output lights, LE, RE, win_L, win_R, score_L, score_R
  );
endinterface

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: conditions the two player keys, walks a single lit
// position along the bar, detects wins, keeps saturating round scores.

module tug_key_cond #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);
  // [STAGES-1:0] is the synchronizer, [STAGES] the previous-value FF.
  logic [STAGES:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[STAGES-1:0], key};
  end

  assign press = sync_pipe[STAGES-1] & ~sync_pipe[STAGES];
endmodule

module tug_playfield #(
  parameter int N_LIGHTS = 9,
  parameter int SCORE_W  = 3
) (
  input logic          clk,
  input logic          reset,
  tug_playfield_if.slave pf
);
  localparam int PW = $clog2(N_LIGHTS);
  localparam logic [PW-1:0] CTR = PW'((N_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] TOP = PW'(N_LIGHTS - 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_WON_L = 2'd1;
  localparam logic [1:0] ST_WON_R = 2'd2;

  logic [1:0]         keys, press;
  logic               lp, rp;
  logic [1:0]         state;
  logic [PW-1:0]      pos;
  logic               win_l, win_r;
  logic [SCORE_W-1:0] score_l, score_r;
  logic [N_LIGHTS-1:0] bar;

  assign keys = {pf.L, pf.R};

  tug_key_cond #(.STAGES(2)) u_key [1:0] (
    .clk   (clk),
    .reset (reset),
    .key   (keys),
    .press (press)
  );

  assign lp = press[1];
  assign rp = press[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_PLAY;
      pos     <= CTR;
      win_l   <= 1'b0;
      win_r   <= 1'b0;
      score_l <= '0;
      score_r <= '0;
    end else begin
      win_l <= 1'b0;
      win_r <= 1'b0;
      if (pf.new_round) begin
        // Round restart beats any same-cycle press.
        state <= ST_PLAY;
        pos   <= CTR;
      end else if (state == ST_PLAY) begin
        if (lp && !rp) begin
          if (pos == TOP) begin
            state <= ST_WON_L;
            win_l <= 1'b1;
            if (score_l != SMAX) score_l <= score_l + 1'b1;
          end else begin
            pos <= pos + 1'b1;
          end
        end else if (rp && !lp) begin
          if (pos == '0) begin
            state <= ST_WON_R;
            win_r <= 1'b1;
            if (score_r != SMAX) score_r <= score_r + 1'b1;
          end else begin
            pos <= pos - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bar = '0;
    for (int i = 0; i < N_LIGHTS; i++) bar[i] = (pos == PW'(i));
  end

  assign pf.lights  = bar;
  assign pf.LE      = (pos == TOP);
  assign pf.RE      = (pos == '0);
  assign pf.win_L   = win_l;
  assign pf.win_R   = win_r;
  assign pf.score_L = score_l;
  assign pf.score_R = score_r;
endmodule
